// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, command record and master state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int unsigned CMD_ADDR_W = 32;
    localparam int unsigned CMD_DATA_W = 32;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0] addr;
        logic                  write;
        logic [2:0]            size;
        logic [CMD_DATA_W-1:0] wdata;
    } ahb_cmd_t;

    typedef enum logic {
        NORMAL = 1'b0,
        ERR2   = 1'b1
    } ahb_state_e;

endpackage

// File: rtl/ahb_cmd_master_if.sv
// Command/response stream plus AHB-Lite master-side bus signals for ahb_cmd_master.
interface ahb_cmd_master_if #(
    parameter int unsigned AHB_ADDR_WIDTH = 32,
    parameter int unsigned AHB_DATA_WIDTH = 32
) ();
    logic                      cmd_valid_in;
    logic                      cmd_ready_out;
    logic [AHB_ADDR_WIDTH-1:0] cmd_addr_in;
    logic                      cmd_write_in;
    logic [2:0]                cmd_size_in;
    logic [AHB_DATA_WIDTH-1:0] cmd_wdata_in;
    logic                      rsp_valid_out;
    logic [AHB_DATA_WIDTH-1:0] rsp_rdata_out;
    logic                      rsp_err_out;
    logic [AHB_ADDR_WIDTH-1:0] haddr_out;
    logic [1:0]                htrans_out;
    logic                      hwrite_out;
    logic [2:0]                hsize_out;
    logic [AHB_DATA_WIDTH-1:0] hwdata_out;
    logic                      hready_in;
    logic                      hresp_in;
    logic [AHB_DATA_WIDTH-1:0] hrdata_in;

    modport master (
        input  cmd_valid_in, cmd_addr_in, cmd_write_in, cmd_size_in, cmd_wdata_in,
        input  hready_in, hresp_in, hrdata_in,
        output cmd_ready_out, rsp_valid_out, rsp_rdata_out, rsp_err_out,
        output haddr_out, htrans_out, hwrite_out, hsize_out, hwdata_out
    );

    modport slave (
        output cmd_valid_in, cmd_addr_in, cmd_write_in, cmd_size_in, cmd_wdata_in,
        output hready_in, hresp_in, hrdata_in,
        input  cmd_ready_out, rsp_valid_out, rsp_rdata_out, rsp_err_out,
        input  haddr_out, htrans_out, hwrite_out, hsize_out, hwdata_out
    );
endinterface

// File: rtl/ahb_wait_timer.sv
// Wait-state watchdog: sticky flag once a data phase stalls TIMEOUT_CYCLES cycles.
// Only built with AHB_CMD_MASTER_TIMEOUT_EN defined.
`ifdef AHB_CMD_MASTER_TIMEOUT_EN
module ahb_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic wait_cycle,
    input  logic clear,
    output logic timeout
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            timeout <= 1'b0;
        end else if (clear) begin
            count_q <= '0;
        end else if (wait_cycle) begin
            // Saturate so a very long stall cannot wrap the count.
            if (32'(count_q) < TIMEOUT_CYCLES) begin
                count_q <= count_q + 1'b1;
            end
            if (32'(count_q) + 32'd1 >= TIMEOUT_CYCLES) begin
                timeout <= 1'b1;
            end
        end
    end
endmodule
`endif

// File: rtl/ahb_cmd_master.sv
// AHB-Lite initiator: valid/ready commands to pipelined single NONSEQ transfers.
// Optional wait-state watchdog output under AHB_CMD_MASTER_TIMEOUT_EN.
module ahb_cmd_master
    import ahb_pkg::*;
#(
    parameter int unsigned AHB_ADDR_WIDTH = 32,
    parameter int unsigned AHB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic             ahb_clk_in,
    input  logic             ahb_rst_in,
`ifdef AHB_CMD_MASTER_TIMEOUT_EN
    output logic             timeout_out,
`endif
    ahb_cmd_master_if.master bus
);
    ahb_cmd_t                  cmd;
    ahb_cmd_t                  aphase_q;
    ahb_state_e                state_q;
    logic [1:0]                htrans_q;
    logic [AHB_DATA_WIDTH-1:0] hwdata_q;
    logic                      dp_valid_q;
    logic                      dp_write_q;
    logic                      cancel_q;
    logic                      cancel_rsp_q;
    logic                      rsp_valid_q;
    logic                      rsp_err_q;
    logic [AHB_DATA_WIDTH-1:0] rsp_rdata_q;
    logic                      cmd_ready;
    logic                      accept;
    logic                      err_first;

    assign cmd.addr  = CMD_ADDR_W'(bus.cmd_addr_in);
    assign cmd.write = bus.cmd_write_in;
    assign cmd.size  = bus.cmd_size_in;
    assign cmd.wdata = CMD_DATA_W'(bus.cmd_wdata_in);

    assign cmd_ready = bus.hready_in && (state_q == NORMAL) && !ahb_rst_in;
    assign accept    = bus.cmd_valid_in && cmd_ready;
    assign err_first = (state_q == NORMAL) && dp_valid_q && bus.hresp_in && !bus.hready_in;

    always_ff @(posedge ahb_clk_in or posedge ahb_rst_in) begin
        if (ahb_rst_in) begin
            aphase_q     <= '0;
            state_q      <= NORMAL;
            htrans_q     <= HTRANS_IDLE;
            hwdata_q     <= '0;
            dp_valid_q   <= 1'b0;
            dp_write_q   <= 1'b0;
            cancel_q     <= 1'b0;
            cancel_rsp_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
            cancel_rsp_q <= 1'b0;
            if (bus.hready_in) begin
                if (accept) begin
                    aphase_q <= cmd;
                    htrans_q <= HTRANS_NONSEQ;
                end else begin
                    htrans_q <= HTRANS_IDLE;
                end
                if (htrans_q == HTRANS_NONSEQ) begin
                    dp_valid_q <= 1'b1;
                    dp_write_q <= aphase_q.write;
                    if (aphase_q.write) begin
                        hwdata_q <= AHB_DATA_WIDTH'(aphase_q.wdata);
                    end
                end else begin
                    dp_valid_q <= 1'b0;
                end
                if (dp_valid_q) begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= bus.hresp_in;
                    rsp_rdata_q <= (!dp_write_q && !bus.hresp_in) ? bus.hrdata_in : '0;
                end
                if (state_q == ERR2) begin
                    state_q      <= NORMAL;
                    cancel_rsp_q <= cancel_q;
                    cancel_q     <= 1'b0;
                end
            end else if (err_first) begin
                // Pull a pending NONSEQ off the bus; it is answered after the error response.
                state_q <= ERR2;
                if (htrans_q == HTRANS_NONSEQ) begin
                    htrans_q <= HTRANS_IDLE;
                    cancel_q <= 1'b1;
                end
            end
            if (cancel_rsp_q) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
                rsp_rdata_q <= '0;
            end
        end
    end

    assign bus.cmd_ready_out = cmd_ready;
    assign bus.haddr_out     = AHB_ADDR_WIDTH'(aphase_q.addr);
    assign bus.htrans_out    = htrans_q;
    assign bus.hwrite_out    = aphase_q.write;
    assign bus.hsize_out     = aphase_q.size;
    assign bus.hwdata_out    = hwdata_q;
    assign bus.rsp_valid_out = rsp_valid_q;
    assign bus.rsp_err_out   = rsp_err_q;
    assign bus.rsp_rdata_out = rsp_rdata_q;

`ifdef AHB_CMD_MASTER_TIMEOUT_EN
    ahb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk       (ahb_clk_in),
        .rst       (ahb_rst_in),
        .wait_cycle(dp_valid_q && !bus.hready_in),
        .clear     (bus.hready_in),
        .timeout   (timeout_out)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif
endmodule

// File: tb/tb_ahb_cmd_master.sv
// Self-checking bench for ahb_cmd_master: vector table, scoreboard and AHB slave model.
module tb_ahb_cmd_master;
    import ahb_pkg::*;

`ifdef AHB_CMD_MASTER_TIMEOUT_EN
    localparam int unsigned TO_CYC = 4;
`else
    localparam int unsigned TO_CYC = 256;
`endif

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic        err;
        logic        chain;
        logic        exp_cancel;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          acc_cyc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic timeout;
    always #5 clk = ~clk;

    ahb_cmd_master_if #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32)) bus_if ();

    ahb_cmd_master #(
        .AHB_ADDR_WIDTH(32),
        .AHB_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .ahb_clk_in(clk),
        .ahb_rst_in(rst),
`ifdef AHB_CMD_MASTER_TIMEOUT_EN
        .timeout_out(timeout),
`endif
        .bus(bus_if.master)
    );
`ifndef AHB_CMD_MASTER_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    vec_t cmd_q[$];
    vec_t slv_q[$];
    exp_t sb_q[$];
    vec_t cur;
    bit   active, hold_chk, err_seen;
    int   wleft;
    logic        last_hready;
    logic [1:0]  last_htrans;
    logic [31:0] last_haddr;
    logic        last_hwrite;
    logic [2:0]  last_hsize;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got 0x%08h, required 0x%08h", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input logic write, input logic [2:0] size,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input int waits, input logic err, input logic chain,
                                input logic cancel, input logic exp_err,
                                input logic [31:0] exp_rdata, input int exp_lat);
        vec_t v;
        v.addr = addr; v.write = write; v.size = size; v.wdata = wdata; v.rdata = rdata;
        v.waits = waits; v.err = err; v.chain = chain; v.exp_cancel = cancel;
        v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_lat = exp_lat;
        return v;
    endfunction

    // One clock: check responses, run the slave model, drive the command, detect accept.
    task automatic cycle();
        exp_t e;
        vec_t v;
        @(negedge clk);
        cyc++;
        if (bus_if.rsp_valid_out === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_rsp @cyc %0d: got rsp_valid=1, required 0", cyc);
            end else begin
                e = sb_q.pop_front();
                check("rsp_err", 32'(bus_if.rsp_err_out), 32'(e.err));
                check("rsp_rdata", bus_if.rsp_rdata_out, e.rdata);
                check("rsp_latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
            end
        end
        if (rst) begin
            active = 0; hold_chk = 0;
            last_hready = 1'b1; last_htrans = HTRANS_IDLE;
            bus_if.hready_in = 1'b1; bus_if.hresp_in = 1'b0; bus_if.hrdata_in = '0;
        end else begin
            if (hold_chk) begin
                check("haddr_hold", bus_if.haddr_out, last_haddr);
                check("htrans_hold", 32'(bus_if.htrans_out), 32'(last_htrans));
            end
            hold_chk = 0;
            if (last_hready) begin
                active = (last_htrans == HTRANS_NONSEQ);
                if (active) begin
                    if (slv_q.size() == 0) begin
                        n_cmp++; n_bad++; active = 0;
                        $display("FAIL unexpected_xfer @cyc %0d: got haddr 0x%08h, required none",
                                 cyc, last_haddr);
                    end else begin
                        cur = slv_q.pop_front();
                        wleft = cur.waits; err_seen = 0;
                        check("haddr", last_haddr, cur.addr);
                        check("hwrite", 32'(last_hwrite), 32'(cur.write));
                        check("hsize", 32'(last_hsize), 32'(cur.size));
                    end
                end
            end
            if (active && cur.write) check("hwdata", bus_if.hwdata_out, cur.wdata);
            last_htrans = bus_if.htrans_out; last_haddr = bus_if.haddr_out;
            last_hwrite = bus_if.hwrite_out; last_hsize = bus_if.hsize_out;
            bus_if.hrdata_in = active ? cur.rdata : 32'h0;
            if (!active) begin
                bus_if.hready_in = 1'b1; bus_if.hresp_in = 1'b0;
            end else if (wleft > 0) begin
                bus_if.hready_in = 1'b0; bus_if.hresp_in = 1'b0; wleft--; hold_chk = 1;
            end else if (cur.err && !err_seen) begin
                bus_if.hready_in = 1'b0; bus_if.hresp_in = 1'b1; err_seen = 1;
            end else if (cur.err) begin
                bus_if.hready_in = 1'b1; bus_if.hresp_in = 1'b1;
                check("htrans_err2", 32'(bus_if.htrans_out), 32'(HTRANS_IDLE));
            end else begin
                bus_if.hready_in = 1'b1; bus_if.hresp_in = 1'b0;
            end
            last_hready = bus_if.hready_in;
        end
        if (!rst && cmd_q.size() != 0) begin
            bus_if.cmd_valid_in = 1'b1;
            bus_if.cmd_addr_in  = cmd_q[0].addr;
            bus_if.cmd_write_in = cmd_q[0].write;
            bus_if.cmd_size_in  = cmd_q[0].size;
            bus_if.cmd_wdata_in = cmd_q[0].wdata;
        end else begin
            bus_if.cmd_valid_in = 1'b0;
        end
        #4;
        if (!bus_if.hready_in) check("cmd_ready_wait", 32'(bus_if.cmd_ready_out), 32'h0);
        if (bus_if.cmd_valid_in && bus_if.cmd_ready_out) begin
            v = cmd_q.pop_front();
            e.err = v.exp_err; e.rdata = v.exp_rdata; e.acc_cyc = cyc; e.lat = v.exp_lat;
            sb_q.push_back(e);
            if (!v.exp_cancel) slv_q.push_back(v);
        end
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while ((cmd_q.size() != 0 || sb_q.size() != 0) && k < 60) begin
            cycle();
            k++;
        end
        if (k >= 60) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_%s: got %0d cmds / %0d rsps outstanding, required 0",
                     tag, cmd_q.size(), sb_q.size());
            cmd_q.delete(); sb_q.delete(); slv_q.delete();
        end
        repeat (2) cycle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd_ready"}, 32'(bus_if.cmd_ready_out), 32'h0);
        check({tag, "_htrans"}, 32'(bus_if.htrans_out), 32'h0);
        check({tag, "_haddr"}, bus_if.haddr_out, 32'h0);
        check({tag, "_hwrite"}, 32'(bus_if.hwrite_out), 32'h0);
        check({tag, "_hsize"}, 32'(bus_if.hsize_out), 32'h0);
        check({tag, "_hwdata"}, bus_if.hwdata_out, 32'h0);
        check({tag, "_rsp_valid"}, 32'(bus_if.rsp_valid_out), 32'h0);
        check({tag, "_rsp_err"}, 32'(bus_if.rsp_err_out), 32'h0);
        check({tag, "_rsp_rdata"}, bus_if.rsp_rdata_out, 32'h0);
    endtask

    localparam int NV = 13;
    vec_t vecs[NV];

    initial begin
        //        addr           w  sz wdata          rdata          wt er ch cx eerr erdata  lat
        vecs[0]  = mk(32'h2030_0400, 1, 2, 32'hA5A5_0001, 32'hBAD0_0000, 0, 0, 0, 0, 0, 32'h0, 3);
        vecs[1]  = mk(32'h2030_0000, 0, 2, 32'h0, 32'h0000_0011, 0, 0, 0, 0, 0, 32'h11, 3);
        vecs[2]  = mk(32'h2030_0800, 0, 2, 32'h0, 32'h0000_0022, 0, 0, 1, 0, 0, 32'h22, 3);
        vecs[3]  = mk(32'h2030_0010, 0, 2, 32'h0, 32'hDEAD_BEEF, 3, 0, 0, 0, 0, 32'hDEAD_BEEF, 6);
        vecs[4]  = mk(32'h2030_0020, 1, 1, 32'h0000_BEEF, 32'hBAD0_0004, 1, 0, 0, 0, 0, 32'h0, 4);
        vecs[5]  = mk(32'h2030_0030, 1, 2, 32'h1234_5678, 32'hBAD0_0005, 0, 1, 0, 0, 1, 32'h0, 4);
        vecs[6]  = mk(32'h2030_0040, 0, 2, 32'h0, 32'h0000_0066, 0, 0, 1, 1, 1, 32'h0, 4);
        vecs[7]  = mk(32'h2030_0050, 0, 2, 32'h0, 32'h0000_0099, 0, 1, 0, 0, 1, 32'h0, 4);
        vecs[8]  = mk(32'h2030_0003, 0, 0, 32'h0, 32'h0000_0055, 0, 0, 0, 0, 0, 32'h55, 3);
        vecs[9]  = mk(32'h2030_0100, 1, 2, 32'h0BAD_CAFE, 32'hBAD0_0009, 0, 0, 0, 0, 0, 32'h0, 3);
        vecs[10] = mk(32'h2030_0104, 0, 2, 32'h0, 32'hCAFE_F00D, 2, 0, 1, 0, 0, 32'hCAFE_F00D, 5);
        vecs[11] = mk(32'h2030_0108, 1, 2, 32'h7777_0001, 32'hBAD0_000B, 0, 0, 1, 0, 0, 32'h0, 5);
        vecs[12] = mk(32'h2030_0060, 0, 3, 32'h0, 32'h0000_0077, 0, 0, 0, 0, 0, 32'h77, 3);

        bus_if.cmd_valid_in = 1'b0; bus_if.cmd_addr_in = '0; bus_if.cmd_write_in = 1'b0;
        bus_if.cmd_size_in = '0; bus_if.cmd_wdata_in = '0;
        bus_if.hready_in = 1'b1; bus_if.hresp_in = 1'b0; bus_if.hrdata_in = '0;
        last_hready = 1'b1; last_htrans = HTRANS_IDLE; active = 0; hold_chk = 0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        check("reset_timeout", 32'(timeout), 32'h0);
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        for (int i = 0; i < NV; i++) begin
            cmd_q.push_back(vecs[i]);
            if (i + 1 < NV && vecs[i + 1].chain) continue;
            drain($sformatf("vec%0d", i));
        end

`ifdef AHB_CMD_MASTER_TIMEOUT_EN
        check("timeout_before", 32'(timeout), 32'h0);
        cmd_q.push_back(mk(32'h2030_0200, 0, 2, 32'h0, 32'h0000_4444, 5, 0, 0, 0, 0, 32'h4444, 8));
        drain("timeout");
        check("timeout_sticky", 32'(timeout), 32'h1);
`endif

        // Reset in the middle of a stalled data phase with another command waiting.
        cmd_q.push_back(mk(32'h2030_0070, 0, 2, 32'h0, 32'h0000_0033, 5, 0, 0, 0, 0, 32'h33, 8));
        repeat (3) cycle();
        cmd_q.push_back(mk(32'h2030_0074, 1, 2, 32'h5555_AAAA, 32'h0, 0, 0, 0, 0, 0, 32'h0, 3));
        cycle();
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("midrst");
        bus_if.cmd_valid_in = 1'b0;
        cmd_q.delete(); sb_q.delete(); slv_q.delete();
        cycle();
        cycle();
        rst = 1'b0;
        repeat (4) begin
            cycle();
            check("no_rsp_after_reset", 32'(bus_if.rsp_valid_out), 32'h0);
        end
        cmd_q.push_back(mk(32'h2030_0078, 0, 2, 32'h0, 32'h0000_7788, 0, 0, 0, 0, 0, 32'h7788, 3));
        drain("recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
